fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Instruction-fetch stage that sits directly upstream of the single-cycle RV32 datapath and feeds it Instr/PC.
//  Issues word-aligned fetch requests to instruction memory over a valid/ready request channel, with in-order responses.
//  Buffers returned words in a small prefetch FIFO and hands them downstream over a valid/ready handshake.
//  Taken branches and jumps from the datapath (redirect) flush the buffer and discard stale in-flight responses.
// PARAMETERS
//  WIDTH_DATA  32  instruction word width
//  WIDTH_ADDR  32  PC / fetch address width
//  RESET_PC    0   first fetch address after reset; bits [1:0] must be 0
//  FIFO_DEPTH  4   prefetch entries; power of two, >=2; also the cap on outstanding requests
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           synchronous, active-low reset
//  imem_req_valid out  1           fetch request valid
//  imem_req_ready in   1           memory accepts request this cycle
//  imem_req_addr  out  WIDTH_ADDR  fetch address, word aligned
//  imem_rsp_valid in   1           response word valid (in request order, >=1 cycle after accept)
//  imem_rsp_data  in   WIDTH_DATA  response instruction word
//  redirect_valid in   1           datapath PCSrc taken: restart fetch
//  redirect_pc    in   WIDTH_ADDR  new fetch PC (bits [1:0] forced to 0)
//  instr_valid    out  1           instr_data/instr_pc hold a valid instruction
//  instr_ready    in   1           datapath consumes the instruction this cycle
//  instr_data     out  WIDTH_DATA  instruction word (to the datapath Instr)
//  instr_pc       out  WIDTH_ADDR  PC of instr_data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=BOOT; fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
//    Outputs are 0 during reset: imem_req_valid, instr_valid, imem_req_addr, instr_data, instr_pc.
//    Reset asserted mid-operation drops all buffered and in-flight words.
//    Responses to pre-reset requests must not arrive after reset; the memory resets with the same rst_n.
//  States:
//    BOOT: one cycle, no request -> FETCH.
//    FETCH: normal issue.
//    DRAIN: stale responses pending; no requests -> FETCH when discard reaches 0.
//  Issue rule: imem_req_valid = (state==FETCH) && (outstanding + fifo_count < FIFO_DEPTH) && !redirect_valid.
//  imem_req_addr = fetch_pc. Addr/valid are held while valid && !ready.
//  On accept (valid&&ready): fetch_pc += 4 (mod 2^WIDTH_ADDR wrap-around); outstanding += 1.
//  Response: rsp_valid && discard==0 pushes {data, pc} into the FIFO; outstanding -= 1.
//    The tagged PC comes from an internal PC-of-oldest-outstanding counter.
//  rsp_valid with discard>0: word dropped, discard -= 1.
//  rsp_valid with outstanding==0 && discard==0: ignored.
//  Output: instr_valid = FIFO non-empty; instr_data/instr_pc = FIFO head (combinational from storage).
//    Pop on instr_valid && instr_ready.
//  Latency: first request is at cycle 1 after reset release. A word returned at cycle N is visible on instr_valid at N+1.
//    Sustained throughput is 1 instr/cycle when memory and consumer never stall.
//  Credit: the issue rule guarantees a push never finds the FIFO full. Push and pop in the same cycle are both allowed.
//  Redirect (highest priority, in any state except BOOT):
//    FIFO flushed (a same-cycle pop/push is void).
//    fetch_pc = {redirect_pc[WIDTH_ADDR-1:2], 2'b00}.
//    discard += outstanding minus any same-cycle response already counted.
//    outstanding = 0.
//    state = DRAIN if the resulting discard>0, else FETCH.
//    imem_req_valid is low in the redirect cycle, even if a request was being held (the held request is abandoned).
//  Redirect in BOOT: fetch_pc loads redirect_pc; still goes to FETCH next.
//  Back-to-back redirects: each one reloads fetch_pc. discard accumulates only over requests that were actually accepted.
//  Counters: outstanding and discard are clog2(FIFO_DEPTH)+1 bits wide. They never exceed FIFO_DEPTH.
// TESTING
//  1. Reset release with RESET_PC=0, memory ready=1, 1-cycle latency, instr_ready=1:
//     -> requests 0x0,0x4,0x8 on cycles 1,2,3; instr_pc 0x0 at cycle 3, then one per cycle.
//  2. instr_ready=0 and memory always ready, DEPTH=4:
//     -> exactly 4 requests accepted, req_valid low afterwards, FIFO holds 0x0..0xC.
//     -> then instr_ready=1 pops them in order and fetch resumes.
//  3. imem_req_ready=0 for 3 cycles with valid high:
//     -> addr stays 0x10 for all 3 cycles; a single accept advances it to 0x14.
//  4. Memory latency 3 with 2 outstanding, then redirect_pc=0x103:
//     -> next request addr 0x100 only after 2 responses are dropped.
//     -> the first instr_pc after the redirect is 0x100, and no stale word reaches the output.
//  5. Redirect in the same cycle as rsp_valid and instr_ready, with the FIFO non-empty:
//     -> FIFO empty next cycle, response dropped, instr_valid=0 until the 0x100 word returns.
//  6. fetch_pc=0xFFFFFFFC accepted -> next addr 0x00000000.
//     Assert rst_n=0 with 2 words in flight -> all outputs 0 next cycle and restart from RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues word-aligned requests to instruction memory, buffers
// in-order responses in a small prefetch FIFO and hands {instr, pc} to the datapath.
module fetch_prefetch_unit #(
    parameter int                    WIDTH_DATA = 32,
    parameter int                    WIDTH_ADDR = 32,
    parameter logic [WIDTH_ADDR-1:0] RESET_PC   = {WIDTH_ADDR{1'b0}},
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WIDTH_ADDR-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [WIDTH_DATA-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [WIDTH_ADDR-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [WIDTH_DATA-1:0] instr_data,
    output logic [WIDTH_ADDR-1:0] instr_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]           OCC_LIMIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1'b1);
    localparam logic [AW-1:0]         PTR_ONE   = AW'(1'b1);
    localparam logic [WIDTH_ADDR-1:0] PC_STEP   = WIDTH_ADDR'(3'd4);
    localparam logic [WIDTH_ADDR-1:0] LOW_MASK  = WIDTH_ADDR'(2'b11);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetchState_t;

    function automatic logic [WIDTH_ADDR-1:0] alignPc(input logic [WIDTH_ADDR-1:0] pc);
        return pc & ~LOW_MASK;
    endfunction

    fetchState_t           state_r, nextState_s;
    logic [WIDTH_ADDR-1:0] fetchPc_r, nextFetchPc_s;
    logic [WIDTH_ADDR-1:0] rspPc_r, nextRspPc_s;
    logic [CW-1:0]         outstanding_r, nextOut_s, outNorm_s;
    logic [CW-1:0]         discard_r, nextDisc_s, discNorm_s;
    logic [CW-1:0]         count_r, nextCount_s;
    logic [AW-1:0]         rdPtr_r, nextRdPtr_s;
    logic [AW-1:0]         wrPtr_r, nextWrPtr_s;
    logic [WIDTH_DATA-1:0] dataMem_r [FIFO_DEPTH];
    logic [WIDTH_ADDR-1:0] pcMem_r   [FIFO_DEPTH];

    logic [CW:0] occupancy_s;
    logic        reqValid_s, accept_s, rspDrop_s, rspTake_s, push_s, pop_s;

    // Handshake decode and next-state computation; redirect overrides everything else
    always_comb begin
        occupancy_s   = {1'b0, outstanding_r} + {1'b0, count_r};
        reqValid_s    = (state_r == FETCH) && (occupancy_s < OCC_LIMIT) && !redirect_valid;
        accept_s      = reqValid_s && imem_req_ready;
        rspDrop_s     = imem_rsp_valid && (discard_r != {CW{1'b0}});
        rspTake_s     = imem_rsp_valid && (discard_r == {CW{1'b0}}) && (outstanding_r != {CW{1'b0}});
        push_s        = rspTake_s && !redirect_valid;
        pop_s         = (count_r != {CW{1'b0}}) && instr_ready && !redirect_valid;
        outNorm_s     = outstanding_r + (accept_s ? CNT_ONE : {CW{1'b0}})
                                      - (rspTake_s ? CNT_ONE : {CW{1'b0}});
        discNorm_s    = discard_r - (rspDrop_s ? CNT_ONE : {CW{1'b0}});
        nextOut_s     = outNorm_s;
        nextDisc_s    = discNorm_s;
        nextFetchPc_s = fetchPc_r;
        nextRspPc_s   = rspPc_r;
        nextState_s   = state_r;
        nextCount_s   = count_r;
        nextRdPtr_s   = rdPtr_r;
        nextWrPtr_s   = wrPtr_r;

        if (redirect_valid) begin
            // A response taken this cycle is already out of outNorm_s, so it is not re-counted
            nextOut_s     = {CW{1'b0}};
            nextDisc_s    = discNorm_s + outNorm_s;
            nextFetchPc_s = alignPc(redirect_pc);
            nextRspPc_s   = alignPc(redirect_pc);
            nextCount_s   = {CW{1'b0}};
            nextRdPtr_s   = {AW{1'b0}};
            nextWrPtr_s   = {AW{1'b0}};
            if ((discNorm_s + outNorm_s) != {CW{1'b0}}) begin
                nextState_s = DRAIN;
            end else begin
                nextState_s = FETCH;
            end
        end else begin
            if (accept_s) begin
                nextFetchPc_s = fetchPc_r + PC_STEP;
            end else begin
                nextFetchPc_s = fetchPc_r;
            end
            if (push_s) begin
                nextRspPc_s = rspPc_r + PC_STEP;
                nextWrPtr_s = wrPtr_r + PTR_ONE;
            end else begin
                nextRspPc_s = rspPc_r;
                nextWrPtr_s = wrPtr_r;
            end
            if (pop_s) begin
                nextRdPtr_s = rdPtr_r + PTR_ONE;
            end else begin
                nextRdPtr_s = rdPtr_r;
            end
            case ({push_s, pop_s})
                2'b10:   nextCount_s = count_r + CNT_ONE;
                2'b01:   nextCount_s = count_r - CNT_ONE;
                default: nextCount_s = count_r;
            endcase
            case (state_r)
                BOOT:    nextState_s = FETCH;
                FETCH:   nextState_s = FETCH;
                DRAIN:   nextState_s = (discNorm_s == {CW{1'b0}}) ? FETCH : DRAIN;
                default: nextState_s = BOOT;
            endcase
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            fetchPc_r     <= RESET_PC;
            rspPc_r       <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            rdPtr_r       <= {AW{1'b0}};
            wrPtr_r       <= {AW{1'b0}};
        end else begin
            state_r       <= nextState_s;
            fetchPc_r     <= nextFetchPc_s;
            rspPc_r       <= nextRspPc_s;
            outstanding_r <= nextOut_s;
            discard_r     <= nextDisc_s;
            count_r       <= nextCount_s;
            rdPtr_r       <= nextRdPtr_s;
            wrPtr_r       <= nextWrPtr_s;
        end
    end

    // Prefetch storage; cleared on reset so the head reads zero while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dataMem_r[i] <= {WIDTH_DATA{1'b0}};
                pcMem_r[i]   <= {WIDTH_ADDR{1'b0}};
            end
        end else if (push_s) begin
            dataMem_r[wrPtr_r] <= imem_rsp_data;
            pcMem_r[wrPtr_r]   <= rspPc_r;
        end
    end

    assign imem_req_valid = reqValid_s;
    assign imem_req_addr  = fetchPc_r;
    assign instr_valid    = (count_r != {CW{1'b0}});
    assign instr_data     = dataMem_r[rdPtr_r];
    assign instr_pc       = pcMem_r[rdPtr_r];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int          nVec = 0;
    int          nMis = 0;
    int          cyc  = 0;
    int          lat  = 1;
    int          nAcc = 0;
    logic        memReady;
    logic [31:0] qAddr [$];
    int          qDue  [$];
    logic        accCap, rspCap;
    logic [31:0] addrCap;

    fetch_prefetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called mid-cycle: present the due response and memory ready, then capture the handshakes
    task automatic drive();
        if (!rst_n) begin
            qAddr.delete();
            qDue.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (qAddr.size() > 0 && qDue[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(qAddr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        imem_req_ready = memReady;
        #1;
        accCap  = rst_n && imem_req_valid && imem_req_ready;
        addrCap = imem_req_addr;
        rspCap  = rst_n && imem_rsp_valid;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rspCap) begin
            void'(qAddr.pop_front());
            void'(qDue.pop_front());
        end
        if (accCap) begin
            qAddr.push_back(addrCap);
            qDue.push_back(cyc + lat);
            nAcc++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        memReady       = 1'b0;
        drive();
        advance();
        drive();
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        advance();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; memReady = 1'b0;

        // Basic streaming, latency 1
        resetDut();
        memReady = 1'b1; lat = 1; instr_ready = 1'b1;
        drive(); chk1("t1_boot_noreq", imem_req_valid, 1'b0); advance();
        drive(); chk1("t1_c1_valid", imem_req_valid, 1'b1); chk("t1_c1_addr", imem_req_addr, 32'h0); advance();
        drive(); chk("t1_c2_addr", imem_req_addr, 32'h4); chk1("t1_c2_ivalid", instr_valid, 1'b0); advance();
        drive(); chk("t1_c3_addr", imem_req_addr, 32'h8); chk1("t1_c3_ivalid", instr_valid, 1'b1);
        chk("t1_c3_pc", instr_pc, 32'h0); chk("t1_c3_data", instr_data, memWord(32'h0)); advance();
        drive(); chk("t1_c4_pc", instr_pc, 32'h4); advance();
        drive(); chk("t1_c5_pc", instr_pc, 32'h8); chk("t1_c5_data", instr_data, memWord(32'h8)); advance();

        // Consumer stalled: credit limit, ordered drain, then a held request
        resetDut();
        memReady = 1'b1; lat = 1; instr_ready = 1'b0; nAcc = 0;
        for (int c = 0; c < 5; c++) begin drive(); advance(); end
        for (int c = 5; c < 9; c++) begin
            drive(); chk1("t2_full_noreq", imem_req_valid, 1'b0); advance();
        end
        chk("t2_accepts", nAcc, 32'd4);
        instr_ready = 1'b1;
        drive(); chk("t2_pop0", instr_pc, 32'h0); chk1("t2_c9_noreq", imem_req_valid, 1'b0); advance();
        memReady = 1'b0;
        drive(); chk("t2_pop1", instr_pc, 32'h4); chk1("t3_hold_v0", imem_req_valid, 1'b1);
        chk("t3_hold_a0", imem_req_addr, 32'h10); advance();
        drive(); chk("t2_pop2", instr_pc, 32'h8); chk("t3_hold_a1", imem_req_addr, 32'h10); advance();
        drive(); chk("t2_pop3", instr_pc, 32'hC); chk("t2_pop3_data", instr_data, memWord(32'hC));
        chk("t3_hold_a2", imem_req_addr, 32'h10); advance();
        memReady = 1'b1;
        drive(); chk1("t2_empty", instr_valid, 1'b0); chk1("t3_acc_v", imem_req_valid, 1'b1);
        chk("t3_acc_a", imem_req_addr, 32'h10); advance();
        drive(); chk("t3_next_a", imem_req_addr, 32'h14); advance();
        drive(); chk1("t3_ivalid", instr_valid, 1'b1); chk("t3_pc", instr_pc, 32'h10); advance();

        // Redirect with two requests in flight, latency 3
        resetDut();
        memReady = 1'b1; lat = 3; instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin drive(); advance(); end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        drive(); chk1("t4_redir_noreq", imem_req_valid, 1'b0); advance();
        redirect_valid = 1'b0;
        for (int c = 4; c < 6; c++) begin
            drive(); chk1("t4_drain_noreq", imem_req_valid, 1'b0); chk1("t4_drain_iv", instr_valid, 1'b0); advance();
        end
        drive(); chk1("t4_req_v", imem_req_valid, 1'b1); chk("t4_req_a", imem_req_addr, 32'h100);
        chk1("t4_c6_iv", instr_valid, 1'b0); advance();
        for (int c = 7; c < 10; c++) begin
            drive(); chk1("t4_nostale", instr_valid, 1'b0); advance();
        end
        drive(); chk1("t4_iv", instr_valid, 1'b1); chk("t4_pc", instr_pc, 32'h100);
        chk("t4_data", instr_data, memWord(32'h100)); advance();

        // Redirect coinciding with response and pop, FIFO non-empty
        resetDut();
        memReady = 1'b1; lat = 1; instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin drive(); advance(); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        drive(); chk1("t5_pre_iv", instr_valid, 1'b1); chk1("t5_redir_noreq", imem_req_valid, 1'b0); advance();
        redirect_valid = 1'b0;
        drive(); chk1("t5_flushed", instr_valid, 1'b0); chk1("t5_req_v", imem_req_valid, 1'b1);
        chk("t5_req_a", imem_req_addr, 32'h100); advance();
        drive(); chk1("t5_c5_iv", instr_valid, 1'b0); advance();
        drive(); chk1("t5_iv", instr_valid, 1'b1); chk("t5_pc", instr_pc, 32'h100); advance();

        // Boot redirect with alignment, address wrap, then reset with words in flight
        resetDut();
        memReady = 1'b1; lat = 2; instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        drive(); chk1("t6_boot_noreq", imem_req_valid, 1'b0); advance();
        redirect_valid = 1'b0;
        drive(); chk1("t6_c1_v", imem_req_valid, 1'b1); chk("t6_c1_a", imem_req_addr, 32'hFFFF_FFFC); advance();
        drive(); chk("t6_wrap_a", imem_req_addr, 32'h0); advance();
        drive(); advance();
        memReady = 1'b0;
        drive(); chk1("t6_iv", instr_valid, 1'b1); chk("t6_pc", instr_pc, 32'hFFFF_FFFC);
        chk("t6_data", instr_data, memWord(32'hFFFF_FFFC));
        resetDut();
        memReady = 1'b1; lat = 1; instr_ready = 1'b1;
        drive(); chk1("t6_rb_noreq", imem_req_valid, 1'b0); advance();
        drive(); chk1("t6_rb_v", imem_req_valid, 1'b1); chk("t6_rb_a", imem_req_addr, 32'h0); advance();
        drive(); advance();
        drive(); chk1("t6_rb_iv", instr_valid, 1'b1); chk("t6_rb_pc", instr_pc, 32'h0);
        chk("t6_rb_data", instr_data, memWord(32'h0)); advance();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
